// File: rtl/gate_chk_pkg.sv
// Shared types and the golden gate function for the gate response checker.
// Gate encodings, FSM states and the expected-output function.
package gate_chk_pkg;

   typedef enum logic [2:0] {
      OP_NOR  = 3'd0,
      OP_NAND = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5
   } gate_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;

   // Reserved selections (6, 7) always expect 0.
   function automatic logic gate_expected(input logic [2:0] op, input logic a, input logic b);
      logic y;
      case (gate_op_e'(op))
         OP_NOR:  y = ~(a | b);
         OP_NAND: y = ~(a & b);
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: the output the device under test should produce.
module gate_ref_model
   import gate_chk_pkg::*;
(
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y
);

   always_comb begin
      y = gate_expected(op, a, b);
   end

endmodule

// File: rtl/gate_resp_checker.sv
// Checks a run of NUM_VEC sampled a/b/c triples against a selected logic gate,
// tracking sample count, error count, input coverage and the first failing input.
module gate_resp_checker
   import gate_chk_pkg::*;
#(
   parameter int NUM_VEC = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       gate_sel,
   input  logic             vld,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       cov,
   output logic [1:0]       first_fail
);

   localparam bit COV_REQ = (NUM_VEC >= 4);

   chk_state_e       state_q, state_d;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] vec_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [3:0]       cov_q;
   logic [1:0]       first_fail_q;
   logic             mismatch_q;
   logic             exp_bit;
   logic             start_run;
   logic             accept;
   logic             last_sample;

   gate_ref_model u_ref (
      .op (op_q),
      .a  (a),
      .b  (b),
      .y  (exp_bit)
   );

   assign start_run   = (state_q != ST_RUN) && start;
   assign accept      = (state_q == ST_RUN) && vld;
   assign last_sample = accept && (vec_cnt_q == CNT_W'(NUM_VEC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)       state_d = ST_RUN;
         ST_RUN:  if (last_sample) state_d = ST_DONE;
         ST_DONE: if (start)       state_d = ST_RUN;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
      pass = done && (err_cnt_q == '0) && (!COV_REQ || (cov_q == 4'hF));
   end

   // A start cycle only clears; any vld arriving with it is deliberately dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= '0;
         vec_cnt_q    <= '0;
         err_cnt_q    <= '0;
         cov_q        <= '0;
         first_fail_q <= '0;
         mismatch_q   <= 1'b0;
      end else begin
         mismatch_q <= 1'b0;
         if (start_run) begin
            op_q         <= gate_sel;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            cov_q        <= '0;
            first_fail_q <= '0;
         end else if (accept) begin
            vec_cnt_q          <= vec_cnt_q + CNT_W'(1);
            cov_q[{a, b}]      <= 1'b1;
            if (c != exp_bit) begin
               mismatch_q <= 1'b1;
               if (err_cnt_q == '0) begin
                  first_fail_q <= {a, b};
               end
               if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

   assign mismatch   = mismatch_q;
   assign vec_cnt    = vec_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign cov        = cov_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Self-checking bench: directed runs with literal expectations plus random
// stimulus compared every cycle against a behavioural model of the checker.
module tb_gate_resp_checker;

   localparam int NUM_VEC = 4;
   localparam int CNT_W   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [2:0]       gate_sel = 3'd0;
   logic             vld = 1'b0;
   logic             a = 1'b0;
   logic             b = 1'b0;
   logic             c = 1'b0;
   logic             busy, done, pass, mismatch;
   logic [CNT_W-1:0] vec_cnt, err_cnt;
   logic [3:0]       cov;
   logic [1:0]       first_fail;

   int checks   = 0;
   int failures = 0;

   gate_resp_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .gate_sel   (gate_sel),
      .vld        (vld),
      .a          (a),
      .b          (b),
      .c          (c),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .mismatch   (mismatch),
      .vec_cnt    (vec_cnt),
      .err_cnt    (err_cnt),
      .cov        (cov),
      .first_fail (first_fail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Gate truth from the count of ones among the inputs.
   function automatic int model_gate(input int op, input int ia, input int ib);
      int s;
      s = ia + ib;
      case (op)
         0: return (s == 0) ? 1 : 0;
         1: return (s != 2) ? 1 : 0;
         2: return (s == 2) ? 1 : 0;
         3: return (s > 0)  ? 1 : 0;
         4: return (s == 1) ? 1 : 0;
         5: return (s != 1) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Behavioural model: phase 0 idle, 1 running, 2 finished.
   int m_phase = 0, m_op = 0, m_cnt = 0, m_err = 0, m_cov = 0, m_ff = 0, m_mm = 0;

   always @(posedge clk) begin
      int idx, e, m_pass;
      if (rst) begin
         m_phase = 0; m_op = 0; m_cnt = 0; m_err = 0; m_cov = 0; m_ff = 0; m_mm = 0;
      end else if (m_phase != 1 && start) begin
         m_phase = 1; m_op = int'(gate_sel); m_cnt = 0; m_err = 0; m_cov = 0; m_ff = 0; m_mm = 0;
      end else if (m_phase == 1 && vld) begin
         idx = int'(a) * 2 + int'(b);
         e   = model_gate(m_op, int'(a), int'(b));
         m_mm = (int'(c) != e) ? 1 : 0;
         if (m_mm == 1) begin
            if (m_err == 0) m_ff = idx;
            if (m_err < (1 << CNT_W) - 1) m_err++;
         end
         m_cov = m_cov | (1 << idx);
         m_cnt++;
         if (m_cnt == NUM_VEC) m_phase = 2;
      end else begin
         m_mm = 0;
      end
      #1;
      m_pass = (m_phase == 2 && m_err == 0 && (NUM_VEC < 4 || m_cov == 15)) ? 1 : 0;
      chk("busy",       int'(busy),       (m_phase == 1) ? 1 : 0);
      chk("done",       int'(done),       (m_phase == 2) ? 1 : 0);
      chk("pass",       int'(pass),       m_pass);
      chk("mismatch",   int'(mismatch),   m_mm);
      chk("vec_cnt",    int'(vec_cnt),    m_cnt);
      chk("err_cnt",    int'(err_cnt),    m_err);
      chk("cov",        int'(cov),        m_cov);
      chk("first_fail", int'(first_fail), m_ff);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start(input int sel);
      start = 1'b1; gate_sel = 3'(sel); tick(); start = 1'b0;
   endtask

   task automatic sample(input int ia, input int ib, input int ic);
      vld = 1'b1; a = 1'(ia); b = 1'(ib); c = 1'(ic); tick(); vld = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_vec",  int'(vec_cnt), 0);

      // Passing NOR run.
      do_start(0);
      chk("nor_busy", int'(busy), 1);
      sample(0, 0, 1); sample(0, 1, 0); sample(1, 0, 0);
      chk("nor_not_done", int'(done), 0);
      sample(1, 1, 0);
      chk("nor_done", int'(done), 1);
      chk("nor_vec",  int'(vec_cnt), 4);
      chk("nor_pass", int'(pass), 1);
      chk("nor_cov",  int'(cov), 15);
      chk("nor_err",  int'(err_cnt), 0);

      // Failing NOR run, second sample wrong (also a restart from DONE).
      do_start(0);
      chk("restart_busy", int'(busy), 1);
      chk("restart_vec",  int'(vec_cnt), 0);
      sample(0, 0, 1);
      chk("fail_mm_quiet", int'(mismatch), 0);
      sample(1, 1, 1);
      chk("fail_mm_pulse", int'(mismatch), 1);
      chk("fail_err",      int'(err_cnt), 1);
      chk("fail_ff",       int'(first_fail), 3);
      sample(0, 1, 0);
      chk("fail_mm_end",   int'(mismatch), 0);
      sample(1, 0, 0);
      chk("fail_done",     int'(done), 1);
      chk("fail_pass",     int'(pass), 0);

      // XOR with incomplete coverage.
      do_start(4);
      repeat (4) sample(0, 1, 1);
      chk("xor_done", int'(done), 1);
      chk("xor_cov",  int'(cov), 2);
      chk("xor_err",  int'(err_cnt), 0);
      chk("xor_pass", int'(pass), 0);

      // Back to IDLE, vld while idle, start coinciding with vld, gaps in RUN.
      rst = 1'b1; tick(); rst = 1'b0;
      sample(1, 1, 0); sample(0, 0, 0);
      chk("idle_vec", int'(vec_cnt), 0);
      vld = 1'b1; a = 1'b0; b = 1'b0; c = 1'b1;
      do_start(3);
      vld = 1'b0;
      chk("startvld_vec", int'(vec_cnt), 0);
      sample(0, 0, 0); tick(); sample(0, 1, 1); tick(); tick();
      sample(1, 0, 1); tick();
      chk("gap_not_done", int'(done), 0);
      sample(1, 1, 1);
      chk("gap_done", int'(done), 1);
      chk("gap_pass", int'(pass), 1);

      // Reset mid-run, then a clean run with an ignored start during RUN.
      do_start(2);
      sample(0, 0, 0); sample(1, 1, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_vec",  int'(vec_cnt), 0);
      chk("midrst_cov",  int'(cov), 0);
      do_start(1);
      sample(0, 0, 1); sample(0, 1, 1);
      start = 1'b1; gate_sel = 3'd0;
      sample(1, 0, 1);
      start = 1'b0;
      chk("ignstart_vec", int'(vec_cnt), 3);
      sample(1, 1, 0);
      chk("nand_done", int'(done), 1);
      chk("nand_pass", int'(pass), 1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 59) == 0);
         start    = ($urandom_range(0, 7) == 0);
         gate_sel = 3'($urandom_range(0, 7));
         vld      = ($urandom_range(0, 2) != 0);
         a        = 1'($urandom_range(0, 1));
         b        = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0)
            c = 1'($urandom_range(0, 1));
         else
            c = 1'(model_gate(m_op, int'(a), int'(b)));
         tick();
      end
      rst = 1'b0; start = 1'b0; vld = 1'b0;
      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
